// File: rtl/cnn_buf_pkg.sv
// Shared definitions for the CNN feature-map buffers.
package cnn_buf_pkg;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_FILL  = 2'd1,
    W_BLOCK = 2'd2
  } wr_state_t;

endpackage

// File: rtl/fmap_bank_ram.sv
// Simple dual-port RAM, one channel of one bank; read data registered and held between reads.
module fmap_bank_ram #(
  parameter int DW = 8,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv_fmap_pingpong.sv
// Ping-pong feature-map buffer: a producer streams whole frames into one bank while
// the consumer randomly reads the other; rd_done hands a bank back to the producer.
module conv_fmap_pingpong
  import cnn_buf_pkg::*;
#(
  parameter int CH = 4,
  parameter int DW = 8,
  parameter int AW = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW:0]      cfg_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [CH*DW-1:0] wr_data,
  output logic             frame_avail,
  output logic [1:0]       frame_cnt,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [CH*DW-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_done,
  output logic             err
);

  wr_state_t     state, state_nx;
  logic [AW-1:0] wr_addr;
  logic          wr_bank, rd_bank;
  logic [AW:0]   len [2];
  logic [AW:0]   cur_len;
  logic          accept, last, inc, dec, rd_issue;
  logic [1:0]    cnt_nx;
  logic          sel_q, has_read;
  logic [DW-1:0] q [2][CH];

  assign wr_ready    = (frame_cnt < 2'd2);
  assign frame_avail = (frame_cnt != 2'd0);

  always_comb begin
    accept   = wr_valid && wr_ready;
    // The first beat of a frame is judged against the live cfg_len, later beats against the latched length.
    cur_len  = (state == W_IDLE) ? cfg_len : len[wr_bank];
    last     = ({1'b0, wr_addr} == (cur_len - (AW+1)'(1)));
    inc      = accept && last;
    dec      = rd_done && frame_avail;
    rd_issue = rd_en && frame_avail;
    cnt_nx   = frame_cnt + {1'b0, inc} - {1'b0, dec};
  end

  always_comb begin
    state_nx = state;
    case (state)
      W_IDLE:  if (accept) state_nx = last ? ((cnt_nx == 2'd2) ? W_BLOCK : W_IDLE) : W_FILL;
      W_FILL:  if (inc) state_nx = (cnt_nx == 2'd2) ? W_BLOCK : W_IDLE;
      W_BLOCK: if (cnt_nx < 2'd2) state_nx = W_IDLE;
      default: state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= W_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr   <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      frame_cnt <= '0;
      rd_valid  <= 1'b0;
      sel_q     <= 1'b0;
      has_read  <= 1'b0;
      err       <= 1'b0;
      len[0]    <= '0;
      len[1]    <= '0;
    end else begin
      frame_cnt <= cnt_nx;
      rd_valid  <= rd_issue;
      if (accept) begin
        if (state == W_IDLE) len[wr_bank] <= cfg_len;
        if (last) begin
          wr_addr <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
      if (dec) rd_bank <= ~rd_bank;
      if (rd_issue) begin
        sel_q    <= rd_bank;
        has_read <= 1'b1;
      end
      if ((rd_en && !frame_avail) || (rd_done && !frame_avail) ||
          (rd_issue && ({1'b0, rd_addr} >= len[rd_bank])))
        err <= 1'b1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar c = 0; c < CH; c++) begin : g_ch
      fmap_bank_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (accept && (wr_bank == 1'(b))),
        .waddr (wr_addr),
        .wdata (wr_data[c*DW +: DW]),
        .re    (rd_issue && (rd_bank == 1'(b))),
        .raddr (rd_addr),
        .rdata (q[b][c])
      );
    end
  end

  // RAM outputs hold between reads, so muxing by the last-read bank keeps rd_data stable.
  always_comb begin
    rd_data = '0;
    if (has_read)
      for (int unsigned c = 0; c < CH; c++) rd_data[c*DW +: DW] = q[sel_q][c];
  end

endmodule

// File: tb/tb_conv_fmap_pingpong.sv
// Directed scenarios plus a random run, checked against a frame-queue model.
module tb_conv_fmap_pingpong;

  localparam int CH = 4, DW = 8, AW = 12, WW = CH*DW;

  logic          clk = 1'b0;
  logic          rst_n, wr_valid, rd_en, rd_done;
  logic [AW:0]   cfg_len;
  logic [WW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic          wr_ready, frame_avail, rd_valid, err;
  logic [1:0]    frame_cnt;
  logic [WW-1:0] rd_data;

  int checks = 0, failures = 0;

  conv_fmap_pingpong #(.CH(CH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .frame_avail(frame_avail), .frame_cnt(frame_cnt), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done), .err(err)
  );

  always #5 clk = ~clk;

  // Model: queue of complete frames (flattened words + lengths) and the frame being filled.
  int unsigned   fq_len[$];
  logic [WW-1:0] fq_data[$];
  logic [WW-1:0] cur[$];
  int unsigned   cur_len;
  bit            m_err, m_valid, m_dknown, m_wbank, m_rbank;
  logic [WW-1:0] m_data;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq_len.delete(); fq_data.delete(); cur.delete();
    m_err = 0; m_valid = 0; m_dknown = 1; m_data = '0; m_wbank = 0; m_rbank = 0;
  endtask

  task automatic model_edge();
    int unsigned n = fq_len.size();
    bit avail = (n > 0);
    m_valid = rd_en && avail;
    if (rd_en && !avail) m_err = 1;
    if (rd_en && avail) begin
      if (rd_addr < fq_len[0]) begin
        m_data = fq_data[rd_addr]; m_dknown = 1;
      end else begin
        m_err = 1; m_dknown = 0;
      end
    end
    if (rd_done) begin
      if (!avail) m_err = 1;
      else begin
        repeat (fq_len[0]) void'(fq_data.pop_front());
        void'(fq_len.pop_front());
        m_rbank = ~m_rbank;
      end
    end
    if (wr_valid && n < 2) begin
      if (cur.size() == 0) cur_len = cfg_len;
      cur.push_back(wr_data);
      if (cur.size() == cur_len) begin
        fq_len.push_back(cur_len);
        foreach (cur[i]) fq_data.push_back(cur[i]);
        cur.delete();
        m_wbank = ~m_wbank;
      end
    end
  endtask

  task automatic check_all();
    int unsigned n = fq_len.size();
    chk("frame_cnt", 64'(frame_cnt), 64'(n));
    chk("frame_avail", 64'(frame_avail), 64'(n != 0));
    chk("wr_ready", 64'(wr_ready), 64'(n < 2));
    chk("rd_valid", 64'(rd_valid), 64'(m_valid));
    chk("err", 64'(err), 64'(m_err));
    chk("wr_addr", 64'(dut.wr_addr), 64'(cur.size()));
    chk("wr_bank", 64'(dut.wr_bank), 64'(m_wbank));
    chk("rd_bank", 64'(dut.rd_bank), 64'(m_rbank));
    if (m_dknown) chk("rd_data", 64'(rd_data), 64'(m_data));
  endtask

  task automatic cycle(bit wv, logic [WW-1:0] wd, logic [AW:0] len, bit re, logic [AW-1:0] ra, bit rd);
    wr_valid = wv; wr_data = wd; cfg_len = len; rd_en = re; rd_addr = ra; rd_done = rd;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 0; wr_valid = 0; rd_en = 0; rd_done = 0; rd_addr = '0; wr_data = '0; cfg_len = 13'd16;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    rst_n = 1;
  endtask

  task automatic write_frame(int unsigned n, logic [WW-1:0] base, logic [AW:0] len);
    for (int unsigned i = 0; i < n; i++) cycle(1, base + WW'(i), len, 0, '0, 0);
  endtask

  initial begin
    // Read at reset exit: error, no read; error sticky until reset.
    do_reset();
    cycle(0, '0, 13'd16, 1, 12'd0, 0);
    chk("s42_err", 64'(err), 64'd1);
    chk("s42_rd_valid", 64'(rd_valid), 64'd0);
    repeat (3) cycle(0, '0, 13'd16, 0, '0, 0);
    chk("s42_err_sticky", 64'(err), 64'd1);
    do_reset();
    chk("s42_err_cleared", 64'(err), 64'd0);

    // One 16-beat frame, read address 5.
    write_frame(16, 32'h03020100, 13'd16);
    chk("s39_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("s39_frame_avail", 64'(frame_avail), 64'd1);
    cycle(0, '0, 13'd16, 1, 12'd5, 0);
    chk("s39_rd_valid", 64'(rd_valid), 64'd1);
    chk("s39_rd_data", 64'(rd_data), 64'h03020105);
    cycle(0, '0, 13'd16, 0, '0, 0);
    chk("s39_rd_data_hold", 64'(rd_data), 64'h03020105);

    // Three frames without rd_done: producer stalls after two.
    do_reset();
    write_frame(32, 32'h10000000, 13'd16);
    chk("s40_wr_ready", 64'(wr_ready), 64'd0);
    chk("s40_frame_cnt", 64'(frame_cnt), 64'd2);
    repeat (3) cycle(1, 32'hDEADBEEF, 13'd16, 0, '0, 0);
    cycle(1, 32'hDEADBEEF, 13'd16, 0, '0, 1);
    chk("s40_wr_ready_after_done", 64'(wr_ready), 64'd1);
    chk("s40_wr_bank", 64'(dut.wr_bank), 64'd0);
    write_frame(16, 32'h30000000, 13'd16);
    cycle(0, '0, 13'd16, 1, 12'd2, 1);
    chk("s40_frame2_data", 64'(rd_data), 64'h10000012);
    cycle(0, '0, 13'd16, 1, 12'd3, 0);
    chk("s40_frame3_data", 64'(rd_data), 64'h30000003);

    // Frame-complete coinciding with rd_done.
    do_reset();
    write_frame(16, 32'h40000000, 13'd16);
    write_frame(15, 32'h50000000, 13'd16);
    cycle(1, 32'h5000000F, 13'd16, 0, '0, 1);
    chk("s41_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("s41_rd_bank", 64'(dut.rd_bank), 64'd1);
    chk("s41_wr_bank", 64'(dut.wr_bank), 64'd0);

    // Single-beat frames.
    do_reset();
    cycle(1, 32'hA1A1A1A1, 13'd1, 0, '0, 0);
    cycle(1, 32'hB2B2B2B2, 13'd1, 0, '0, 0);
    cycle(1, 32'hC3C3C3C3, 13'd1, 0, '0, 0);
    chk("s43_frame_cnt", 64'(frame_cnt), 64'd2);
    cycle(0, '0, 13'd1, 1, 12'd0, 0);
    chk("s43_beat1", 64'(rd_data), 64'hA1A1A1A1);
    cycle(0, '0, 13'd1, 0, '0, 1);
    cycle(0, '0, 13'd1, 1, 12'd0, 0);
    chk("s43_beat2", 64'(rd_data), 64'hB2B2B2B2);

    // Reset mid-frame, then a fresh frame.
    do_reset();
    write_frame(7, 32'h60000000, 13'd16);
    do_reset();
    chk("s44_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("s44_wr_addr", 64'(dut.wr_addr), 64'd0);
    write_frame(16, 32'h70000000, 13'd16);
    cycle(0, '0, 13'd16, 1, 12'd9, 0);
    chk("s44_rd_data", 64'(rd_data), 64'h70000009);
    cycle(0, '0, 13'd16, 1, 12'd15, 0);
    chk("s44_rd_data_last", 64'(rd_data), 64'h7000000F);

    // Random traffic; cfg_len wanders mid-frame and reads may overrun the frame.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) < 6), $urandom(), 13'($urandom_range(1, 6)),
            ($urandom_range(0, 9) < 4), 12'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
